stage_ex_mc: RTL and testbench

//  Parametrised execute stage: decodes ALU operand sources, runs single-cycle ALU ops, and runs an

---
 rtl/stage_ex_mc_pkg.sv | 26 ++
 rtl/stage_ex_mc_mul_iter.sv | 64 ++++++
 rtl/stage_ex_mc.sv | 159 +++++++++++++++
 tb/tb_stage_ex_mc.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/stage_ex_mc_pkg.sv
// Shared encodings for the execute stage: ALU operand sources, ALU op codes and FSM states.
package stage_ex_mc_pkg;

    localparam int unsigned ALU_SRC_W = 1;
    localparam logic [ALU_SRC_W-1:0] ALU_SRC_R   = 1'b0;
    localparam logic [ALU_SRC_W-1:0] ALU_SRC_IMM = 1'b1;

    typedef enum logic [3:0] {
        ALU_OP_ADD = 4'd0,
        ALU_OP_SUB = 4'd1,
        ALU_OP_AND = 4'd2,
        ALU_OP_XOR = 4'd3,
        ALU_OP_OR  = 4'd4,
        ALU_OP_SLL = 4'd5,
        ALU_OP_SRL = 4'd6,
        ALU_OP_SLT = 4'd7,
        ALU_OP_MUL = 4'd8
    } alu_op_e;

    typedef enum logic [1:0] {
        EX_ST_IDLE = 2'd0,
        EX_ST_MUL  = 2'd1,
        EX_ST_DONE = 2'd2
    } ex_state_e;

endpackage

// File: rtl/stage_ex_mc_mul_iter.sv
// Iterative shift-add multiplier retiring MUL_STEP multiplier bits per enabled cycle (low DATA_W bits).
module ex_mul_iter #(
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned MUL_STEP = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              start,
    input  logic              kill,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic              done,
    output logic [DATA_W-1:0] product
);

    localparam int unsigned N     = DATA_W / MUL_STEP;
    localparam int unsigned CNT_W = $clog2(N + 1);

    logic              run_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [DATA_W-1:0] mcand_q;
    logic [DATA_W-1:0] mplier_q;
    logic [DATA_W-1:0] acc_q;
    logic [DATA_W-1:0] acc_d;

    always_comb begin
        acc_d = acc_q;
        for (int unsigned j = 0; j < MUL_STEP; j++) begin
            if (mplier_q[j]) acc_d = acc_d + (mcand_q << j);
        end
    end

    // done marks the cycle whose enabled edge retires the final iteration
    assign done    = run_q && (cnt_q == CNT_W'(N - 1));
    assign product = acc_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_q    <= 1'b0;
            cnt_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
        end else if (en) begin
            if (kill) begin
                run_q <= 1'b0;
            end else if (start) begin
                run_q    <= 1'b1;
                cnt_q    <= '0;
                mcand_q  <= a;
                mplier_q <= b;
                acc_q    <= '0;
            end else if (run_q) begin
                acc_q    <= acc_d;
                mcand_q  <= mcand_q << MUL_STEP;
                mplier_q <= mplier_q >> MUL_STEP;
                cnt_q    <= cnt_q + 1'b1;
                if (done) run_q <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/stage_ex_mc.sv
// Execute stage: operand muxes, single-cycle ALU, multi-cycle multiply FSM and STAGE_MEM output regs.
// Define STAGE_EX_FWD_EN to enable the EX->EX bypass of the previous result into the operands.
module stage_ex_mc
    import stage_ex_mc_pkg::*;
#(
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned REG_ADDR_W = 5,
    parameter int unsigned MUL_STEP   = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic                  stall,
    input  logic                  flush,
    input  logic                  kill,
    input  logic                  reg_wr,
    input  logic [REG_ADDR_W-1:0] reg_addr_rd,
    input  logic [REG_ADDR_W-1:0] reg_addr_r1,
    input  logic [REG_ADDR_W-1:0] reg_addr_r2,
    input  logic [3:0]            alu_op,
    input  logic [ALU_SRC_W-1:0]  alu_src_arg1,
    input  logic [ALU_SRC_W-1:0]  alu_src_arg2,
    input  logic [DATA_W-1:0]     imm,
    input  logic [DATA_W-1:0]     reg_data_r1,
    input  logic [DATA_W-1:0]     reg_data_r2,
    output logic                  out_reg_wr,
    output logic [REG_ADDR_W-1:0] out_reg_addr_rd,
    output logic [DATA_W-1:0]     out_alu_res,
    output logic                  out_flush,
    output logic                  busy
);

    localparam int unsigned SH_W = $clog2(DATA_W);

    ex_state_e             state_q;
    logic                  mul_wr_q;
    logic [REG_ADDR_W-1:0] mul_rd_q;
    logic                  out_reg_wr_q, out_reg_wr_d;
    logic [REG_ADDR_W-1:0] out_reg_addr_rd_q, out_reg_addr_rd_d;
    logic [DATA_W-1:0]     out_alu_res_q, out_alu_res_d;
    logic                  out_flush_q, out_flush_d;
    logic                  out_ld;
    logic [DATA_W-1:0]     arg1, arg2, alu_res;
    logic [DATA_W-1:0]     mul_prod;
    logic                  mul_start, mul_done, mul_kill;

`ifdef STAGE_EX_FWD_EN
    logic fwd_ok;
    assign fwd_ok = out_reg_wr_q && !out_flush_q && (out_reg_addr_rd_q != '0);
`else
    logic unused_src_addr;
    assign unused_src_addr = ^{reg_addr_r1, reg_addr_r2};
`endif

    always_comb begin
        arg1 = (alu_src_arg1 == ALU_SRC_R) ? reg_data_r1 : imm;
        arg2 = (alu_src_arg2 == ALU_SRC_R) ? reg_data_r2 : imm;
`ifdef STAGE_EX_FWD_EN
        if (fwd_ok && alu_src_arg1 == ALU_SRC_R && out_reg_addr_rd_q == reg_addr_r1) arg1 = out_alu_res_q;
        if (fwd_ok && alu_src_arg2 == ALU_SRC_R && out_reg_addr_rd_q == reg_addr_r2) arg2 = out_alu_res_q;
`endif
    end

    always_comb begin
        alu_res = '0;
        case (alu_op)
            ALU_OP_ADD: alu_res = arg1 + arg2;
            ALU_OP_SUB: alu_res = arg1 - arg2;
            ALU_OP_AND: alu_res = arg1 & arg2;
            ALU_OP_XOR: alu_res = arg1 ^ arg2;
            ALU_OP_OR:  alu_res = arg1 | arg2;
            ALU_OP_SLL: alu_res = arg1 << arg2[SH_W-1:0];
            ALU_OP_SRL: alu_res = arg1 >> arg2[SH_W-1:0];
            ALU_OP_SLT: alu_res = DATA_W'($signed(arg1) < $signed(arg2));
            default:    alu_res = '0;
        endcase
    end

    assign mul_start = (state_q == EX_ST_IDLE) && en && !flush && (alu_op == ALU_OP_MUL);
    assign mul_kill  = kill && (state_q != EX_ST_IDLE);

    // a kill releases upstream in the same cycle it retires the multiply
    assign busy = rst_n && (mul_start
                         || (state_q == EX_ST_MUL && !kill)
                         || (state_q == EX_ST_DONE && !kill && (stall || !en)));

    ex_mul_iter #(
        .DATA_W   (DATA_W),
        .MUL_STEP (MUL_STEP)
    ) u_mul (
        .clk     (clk),
        .rst_n   (rst_n),
        .en      (en),
        .start   (mul_start),
        .kill    (mul_kill),
        .a       (arg1),
        .b       (arg2),
        .done    (mul_done),
        .product (mul_prod)
    );

    // Every load that is neither a single-cycle result nor a multiply commit is a bubble
    always_comb begin
        out_ld            = en && !stall;
        out_reg_wr_d      = 1'b0;
        out_flush_d       = 1'b1;
        out_reg_addr_rd_d = '0;
        out_alu_res_d     = '0;
        if (state_q == EX_ST_IDLE && !flush && alu_op != ALU_OP_MUL) begin
            out_reg_wr_d      = reg_wr;
            out_flush_d       = 1'b0;
            out_reg_addr_rd_d = reg_addr_rd;
            out_alu_res_d     = alu_res;
        end else if (state_q == EX_ST_DONE && !kill) begin
            out_reg_wr_d      = mul_wr_q;
            out_flush_d       = 1'b0;
            out_reg_addr_rd_d = mul_rd_q;
            out_alu_res_d     = mul_prod;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q           <= EX_ST_IDLE;
            mul_wr_q          <= 1'b0;
            mul_rd_q          <= '0;
            out_reg_wr_q      <= 1'b0;
            out_reg_addr_rd_q <= '0;
            out_alu_res_q     <= '0;
            out_flush_q       <= 1'b1;
        end else if (en) begin
            case (state_q)
                EX_ST_IDLE: if (mul_start) begin
                    state_q  <= EX_ST_MUL;
                    mul_wr_q <= reg_wr;
                    mul_rd_q <= reg_addr_rd;
                end
                EX_ST_MUL: begin
                    if (kill)          state_q <= EX_ST_IDLE;
                    else if (mul_done) state_q <= EX_ST_DONE;
                end
                EX_ST_DONE: if (kill || !stall) state_q <= EX_ST_IDLE;
                default:    state_q <= EX_ST_IDLE;
            endcase
            if (out_ld) begin
                out_reg_wr_q      <= out_reg_wr_d;
                out_reg_addr_rd_q <= out_reg_addr_rd_d;
                out_alu_res_q     <= out_alu_res_d;
                out_flush_q       <= out_flush_d;
            end
        end
    end

    assign out_reg_wr      = out_reg_wr_q;
    assign out_reg_addr_rd = out_reg_addr_rd_q;
    assign out_alu_res     = out_alu_res_q;
    assign out_flush       = out_flush_q;

endmodule

// File: tb/tb_stage_ex_mc.sv
// Self-checking bench for stage_ex_mc: directed scenarios plus randomized traffic against a behavioural model.
module tb_stage_ex_mc;
    import stage_ex_mc_pkg::*;

    localparam int DW   = 32;
    localparam int AW   = 5;
    localparam int STEP = 2;
    localparam int N    = DW / STEP;
    localparam bit FWD_ON =
`ifdef STAGE_EX_FWD_EN
        1'b1;
`else
        1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n, en, stall, flush, kill, reg_wr;
    logic [AW-1:0] rd, r1, r2;
    logic [3:0] op;
    logic [ALU_SRC_W-1:0] s1, s2;
    logic [DW-1:0] imm, d1, d2;
    logic o_wr, o_flush, busy;
    logic [AW-1:0] o_rd;
    logic [DW-1:0] o_res;

    int n_total = 0;
    int n_bad   = 0;

    // Model: expected output registers plus pending multiply (m_rem = iterations left, -1 = none)
    logic e_wr, e_flush;
    logic [AW-1:0] e_rd;
    logic [DW-1:0] e_res;
    int m_rem = -1;
    logic [DW-1:0] m_prod;
    logic [AW-1:0] m_rd;
    logic m_wr;
    bit last_adv;

    always #5 clk = ~clk;

    stage_ex_mc #(.DATA_W(DW), .REG_ADDR_W(AW), .MUL_STEP(STEP)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .stall(stall), .flush(flush), .kill(kill),
        .reg_wr(reg_wr), .reg_addr_rd(rd), .reg_addr_r1(r1), .reg_addr_r2(r2),
        .alu_op(op), .alu_src_arg1(s1), .alu_src_arg2(s2), .imm(imm),
        .reg_data_r1(d1), .reg_data_r2(d2),
        .out_reg_wr(o_wr), .out_reg_addr_rd(o_rd), .out_alu_res(o_res),
        .out_flush(o_flush), .busy(busy)
    );

    task automatic check_eq(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] want);
        n_total++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %h want %h at %0t", tag, got, want, $time);
        end
    endtask

    function automatic logic [DW-1:0] ref_alu(input logic [3:0] f, input logic [DW-1:0] a, input logic [DW-1:0] b);
        case (f)
            ALU_OP_ADD: return a + b;
            ALU_OP_SUB: return a - b;
            ALU_OP_AND: return a & b;
            ALU_OP_XOR: return a ^ b;
            ALU_OP_OR:  return a | b;
            ALU_OP_SLL: return a << (b % DW);
            ALU_OP_SRL: return a >> (b % DW);
            ALU_OP_SLT: return ($signed(a) < $signed(b)) ? 1 : 0;
            default:    return '0;
        endcase
    endfunction

    function automatic logic [DW-1:0] opnd(input logic [ALU_SRC_W-1:0] src, input logic [AW-1:0] addr,
                                           input logic [DW-1:0] data);
        bit hit;
        if (src != ALU_SRC_R) return imm;
        hit = e_wr && !e_flush && (e_rd != 0) && (e_rd == addr);
        return (FWD_ON && hit) ? e_res : data;
    endfunction

    function automatic logic want_busy();
        if (!rst_n) return 1'b0;
        if (m_rem < 0) return en && !flush && (op == ALU_OP_MUL);
        if (kill) return 1'b0;
        if (m_rem > 0) return 1'b1;
        return stall || !en;
    endfunction

    task automatic m_bubble();
        e_wr = 1'b0; e_flush = 1'b1; e_rd = '0; e_res = '0;
    endtask

    task automatic m_reset();
        m_bubble();
        m_rem = -1;
    endtask

    task automatic m_edge();
        logic [DW-1:0] a, b;
        logic [2*DW-1:0] p;
        a = opnd(s1, r1, d1);
        b = opnd(s2, r2, d2);
        if (!en) return;
        if (m_rem < 0) begin
            if (!flush && op == ALU_OP_MUL) begin
                p = {{DW{1'b0}}, a} * {{DW{1'b0}}, b};
                m_prod = p[DW-1:0];
                m_rem = N; m_rd = rd; m_wr = reg_wr;
                if (!stall) m_bubble();
            end else if (!stall) begin
                if (flush) m_bubble();
                else begin
                    e_wr = reg_wr; e_flush = 1'b0; e_rd = rd; e_res = ref_alu(op, a, b);
                end
            end
        end else if (kill) begin
            m_rem = -1;
            if (!stall) m_bubble();
        end else if (m_rem > 0) begin
            m_rem--;
            if (!stall) m_bubble();
        end else if (!stall) begin
            e_wr = m_wr; e_flush = 1'b0; e_rd = m_rd; e_res = m_prod;
            m_rem = -1;
        end
    endtask

    task automatic check_outs();
        check_eq("out_reg_wr", o_wr, e_wr);
        check_eq("out_flush", o_flush, e_flush);
        check_eq("out_reg_addr_rd", o_rd, e_rd);
        check_eq("out_alu_res", o_res, e_res);
    endtask

    task automatic cycle();
        logic wb;
        #1;
        wb = want_busy();
        check_eq("busy", busy, wb);
        last_adv = en && !stall && !wb;
        @(posedge clk);
        m_edge();
        #1;
        check_outs();
    endtask

    task automatic set_instr(input logic [3:0] f, input logic [AW-1:0] d, input logic w,
                             input logic [ALU_SRC_W-1:0] a_src, input logic [DW-1:0] a_v,
                             input logic [ALU_SRC_W-1:0] b_src, input logic [DW-1:0] b_v,
                             input logic [DW-1:0] im);
        op = f; rd = d; reg_wr = w; s1 = a_src; d1 = a_v; s2 = b_src; d2 = b_v; imm = im;
        r1 = '0; r2 = '0; flush = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; en = 1'b1; stall = 1'b0; kill = 1'b0;
        set_instr(ALU_OP_ADD, 5'd0, 1'b0, ALU_SRC_R, '0, ALU_SRC_R, '0, '0);
        m_reset();
        #12;
        check_outs();
        check_eq("rst_busy0", busy, 1'b0);
        @(negedge clk) rst_n = 1'b1;

        // wrap-around add, signed compare, shift amount modulo width
        set_instr(ALU_OP_ADD, 5'd5, 1'b1, ALU_SRC_R, 32'hFFFF_FFFF, ALU_SRC_IMM, '0, 32'd1);
        cycle(); check_eq("add_wrap", o_res, 32'h0);
        set_instr(ALU_OP_SLT, 5'd6, 1'b1, ALU_SRC_R, 32'hFFFF_FFFF, ALU_SRC_R, 32'd1, '0);
        cycle(); check_eq("slt_neg", o_res, 32'd1);
        set_instr(ALU_OP_SRL, 5'd7, 1'b1, ALU_SRC_R, 32'h8000_0000, ALU_SRC_IMM, '0, 32'd35);
        cycle(); check_eq("srl_35", o_res, 32'h1000_0000);
        set_instr(4'd13, 5'd8, 1'b1, ALU_SRC_R, 32'h1234, ALU_SRC_R, 32'h5678, '0);
        cycle(); check_eq("undef_op", o_res, 32'h0);

        // 7*6: accept edge, N iterations, then commit
        set_instr(ALU_OP_MUL, 5'd9, 1'b1, ALU_SRC_R, 32'd7, ALU_SRC_R, 32'd6, '0);
        cycle();
        repeat (N) cycle();
        check_eq("mul_bubble", o_flush, 1'b1);
        cycle();
        check_eq("mul_res", o_res, 32'd42);
        check_eq("mul_flush", o_flush, 1'b0);
        set_instr(ALU_OP_SUB, 5'd10, 1'b1, ALU_SRC_R, 32'd50, ALU_SRC_IMM, '0, 32'd8);
        cycle(); check_eq("after_mul", o_res, 32'd42);

        // max*max with three stalled cycles in DONE
        set_instr(ALU_OP_MUL, 5'd11, 1'b1, ALU_SRC_R, 32'hFFFF_FFFF, ALU_SRC_R, 32'hFFFF_FFFF, '0);
        cycle();
        repeat (N) cycle();
        stall = 1'b1;
        repeat (3) begin
            #1 check_eq("stall_busy", busy, 1'b1);
            cycle();
        end
        stall = 1'b0;
        cycle();
        check_eq("mul_max", o_res, 32'h0000_0001);

        // kill after five iterations
        set_instr(ALU_OP_MUL, 5'd12, 1'b1, ALU_SRC_R, 32'd3, ALU_SRC_R, 32'd9, '0);
        cycle();
        repeat (5) cycle();
        kill = 1'b1;
        cycle();
        kill = 1'b0;
        check_eq("kill_wr", o_wr, 1'b0);
        check_eq("kill_flush", o_flush, 1'b1);
        set_instr(ALU_OP_ADD, 5'd13, 1'b1, ALU_SRC_R, 32'd2, ALU_SRC_R, 32'd3, '0);
        cycle(); check_eq("kill_next", o_res, 32'd5);

        // bypass of previous result into operand 1
        set_instr(ALU_OP_ADD, 5'd3, 1'b1, ALU_SRC_R, 32'd5, ALU_SRC_R, 32'd5, '0);
        cycle();
        set_instr(ALU_OP_ADD, 5'd4, 1'b1, ALU_SRC_R, 32'd0, ALU_SRC_IMM, '0, 32'd1);
        r1 = 5'd3;
        cycle(); check_eq("fwd", o_res, FWD_ON ? 32'd11 : 32'd1);

        // asynchronous reset in the middle of a multiply
        set_instr(ALU_OP_MUL, 5'd14, 1'b1, ALU_SRC_R, 32'd7, ALU_SRC_R, 32'd7, '0);
        cycle(); cycle(); cycle();
        #2 rst_n = 1'b0;
        m_reset();
        #1;
        check_eq("rst_mid_busy", busy, 1'b0);
        check_eq("rst_mid_flush", o_flush, 1'b1);
        check_eq("rst_mid_res", o_res, 32'h0);
        @(negedge clk) rst_n = 1'b1;
        set_instr(ALU_OP_ADD, 5'd15, 1'b1, ALU_SRC_R, 32'd100, ALU_SRC_IMM, '0, 32'd23);
        cycle(); check_eq("rst_next_add", o_res, 32'd123);

        // randomized traffic; upstream only advances when the stage accepted its instruction
        last_adv = 1'b1;
        for (int i = 0; i < 1500; i++) begin
            if (last_adv) begin
                op     = 4'($urandom_range(0, 9));
                if ($urandom % 4 == 0) op = ALU_OP_MUL;
                rd     = AW'($urandom % 8);
                r1     = AW'($urandom % 8);
                r2     = AW'($urandom % 8);
                reg_wr = 1'($urandom);
                s1     = ALU_SRC_W'($urandom);
                s2     = ALU_SRC_W'($urandom);
                d1     = $urandom;
                d2     = ($urandom % 3 == 0) ? DW'($urandom % 40) : $urandom;
                imm    = ($urandom % 2 == 0) ? DW'($urandom % 40) : $urandom;
                flush  = ($urandom % 6 == 0);
            end
            en    = ($urandom % 8) != 0;
            stall = ($urandom % 5) == 0;
            kill  = en && (($urandom % 12) == 0);
            cycle();
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
